// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and counter sizing.
package reset_seq_pkg;

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] HOLD      = 2'd1;
  localparam logic [1:0] RELEASE   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  // One bit of headroom above the largest terminal count.
  function automatic int ctr_w(input int lock_c, input int reset_c, input int stage_c);
    int m;
    m = lock_c;
    if (reset_c > m) m = reset_c;
    if (stage_c > m) m = stage_c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-high clear.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_seq.sv
// Multi-channel reset sequencer: waits for stable PLL lock, holds, then releases
// active-low channel resets in a staggered order; restarts on lock loss or warm reset.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int LOCK_CYCLES  = 16,
  parameter int RESET_CYCLES = 200,
  parameter int STAGE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              sw_rst_req,
  output logic              sw_rst_ack,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              ready
);

  localparam int CTR_W = ctr_w(LOCK_CYCLES, RESET_CYCLES, STAGE_CYCLES);
  localparam int IDX_W = $clog2(NUM_CH) + 1;

  localparam logic [CTR_W-1:0]  LOCK_LAST  = CTR_W'(LOCK_CYCLES - 1);
  localparam logic [CTR_W-1:0]  RESET_LAST = CTR_W'(RESET_CYCLES - 1);
  localparam logic [CTR_W-1:0]  STAGE_LAST = CTR_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] CH0        = NUM_CH'(1);

  logic              lock_s;
  logic [1:0]        state_q, state_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              ready_q, ready_d;
  logic              ack_q, ack_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_lock),
    .q_o (lock_s)
  );

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    ack_d   = 1'b0;
    // Lock loss outranks every other transition and drops all channels at once.
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d = WAIT_LOCK;
      ctr_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!lock_s) begin
            ctr_d = '0;
          end else if (ctr_q == LOCK_LAST) begin
            state_d = HOLD;
            ctr_d   = '0;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
        HOLD: begin
          if (ctr_q == RESET_LAST) begin
            ctr_d   = '0;
            idx_d   = IDX_W'(1);
            rst_n_d = CH0;
            if (NUM_CH == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
        RELEASE: begin
          if (ctr_q == STAGE_LAST) begin
            ctr_d   = '0;
            idx_d   = idx_q + 1'b1;
            rst_n_d = rst_n_q | (CH0 << idx_q);
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
        RUN: begin
          // Warm reset skips the lock wait since lock is known good here.
          if (sw_rst_req) begin
            state_d = HOLD;
            ctr_d   = '0;
            rst_n_d = '0;
            ready_d = 1'b0;
            ack_d   = 1'b1;
          end
        end
        default: begin
          state_d = WAIT_LOCK;
          ctr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      ctr_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign rst_n_out  = rst_n_q;
  assign ready      = ready_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: expected output levels are queued per clock edge
// together with the input levels to drive after that edge.
module tb_reset_seq;

  typedef struct {
    int         e;
    logic [2:0] rn;
    logic       rdy;
    logic       ack;
    logic       req;
    logic       lock;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       ack0, rdy0, ack1, rdy1;
  logic [2:0] rn0;
  logic [0:0] rn1;

  int   checks = 0;
  int   failures = 0;
  int   ecnt = 0;
  exp_t sb[$];
  exp_t x;

  always #5 clk = ~clk;

  reset_seq #(.NUM_CH(3), .LOCK_CYCLES(2), .RESET_CYCLES(8), .STAGE_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
    .sw_rst_ack(ack0), .rst_n_out(rn0), .ready(rdy0)
  );

  reset_seq #(.NUM_CH(1), .LOCK_CYCLES(2), .RESET_CYCLES(8), .STAGE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
    .sw_rst_ack(ack1), .rst_n_out(rn1), .ready(rdy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  // Next posedge after this becomes edge 0.
  task automatic release_rst();
    step();
    rst = 1'b0;
    ecnt = -1;
  endtask

  function automatic void push(input int e, input logic [2:0] rn, input logic rdy,
                               input logic ack, input logic req, input logic lock);
    exp_t t;
    t.e = e; t.rn = rn; t.rdy = rdy; t.ack = ack; t.req = req; t.lock = lock;
    sb.push_back(t);
  endfunction

  task automatic test_reset();
    rst = 1'b1; pll_lock = 1'b1; sw_rst_req = 1'b0;
    repeat (3) step();
    checks++;
    if ({rn0, rdy0, ack0} !== 5'b0) begin
      failures++;
      $display("FAIL reset_main got rn=%b rdy=%b ack=%b exp all 0", rn0, rdy0, ack0);
    end
    checks++;
    if ({rn1, rdy1, ack1} !== 3'b0) begin
      failures++;
      $display("FAIL reset_sweep got rn=%b rdy=%b ack=%b exp all 0", rn1, rdy1, ack1);
    end
  endtask

  task automatic test_cold_start();
    release_rst();
    push(0, 3'b000, 0, 0, 0, 1);  push(10, 3'b000, 0, 0, 0, 1);
    push(11, 3'b001, 0, 0, 0, 1); push(14, 3'b001, 0, 0, 0, 1);
    push(15, 3'b011, 0, 0, 0, 1); push(18, 3'b011, 0, 0, 0, 1);
    push(19, 3'b111, 1, 0, 0, 1); push(20, 3'b111, 1, 0, 0, 1);
    while (sb.size() > 0) begin
      step();
      while (sb.size() > 0 && sb[0].e == ecnt) begin
        x = sb.pop_front();
        checks++;
        if ({rn0, rdy0, ack0} !== {x.rn, x.rdy, x.ack}) begin
          failures++;
          $display("FAIL cold_start edge=%0d got rn=%b rdy=%b ack=%b exp rn=%b rdy=%b ack=%b",
                   ecnt, rn0, rdy0, ack0, x.rn, x.rdy, x.ack);
        end
        sw_rst_req = x.req; pll_lock = x.lock;
      end
    end
  endtask

  task automatic test_late_lock();
    rst = 1'b1; pll_lock = 1'b0;
    release_rst();
    push(9, 3'b000, 0, 0, 0, 1);   // one-cycle glitch sampled at edge 10
    push(10, 3'b000, 0, 0, 0, 0);
    push(29, 3'b000, 0, 0, 0, 1);  // stable lock sampled from edge 30
    push(40, 3'b000, 0, 0, 0, 1); push(41, 3'b001, 0, 0, 0, 1);
    push(44, 3'b001, 0, 0, 0, 1); push(45, 3'b011, 0, 0, 0, 1);
    push(48, 3'b011, 0, 0, 0, 1); push(49, 3'b111, 1, 0, 0, 1);
    while (sb.size() > 0) begin
      step();
      while (sb.size() > 0 && sb[0].e == ecnt) begin
        x = sb.pop_front();
        checks++;
        if ({rn0, rdy0, ack0} !== {x.rn, x.rdy, x.ack}) begin
          failures++;
          $display("FAIL late_lock edge=%0d got rn=%b rdy=%b ack=%b exp rn=%b rdy=%b ack=%b",
                   ecnt, rn0, rdy0, ack0, x.rn, x.rdy, x.ack);
        end
        sw_rst_req = x.req; pll_lock = x.lock;
      end
    end
  endtask

  task automatic test_warm_reset();
    int n;
    n = ecnt + 2;
    push(n - 1, 3'b111, 1, 0, 1, 1);   // request sampled at edge n
    push(n,      3'b000, 0, 1, 0, 1);
    push(n + 1,  3'b000, 0, 0, 0, 1);
    push(n + 3,  3'b000, 0, 0, 1, 1);  // request during HOLD, ignored
    push(n + 4,  3'b000, 0, 0, 0, 1);
    push(n + 7,  3'b000, 0, 0, 0, 1);
    push(n + 8,  3'b001, 0, 0, 0, 1);
    push(n + 12, 3'b011, 0, 0, 0, 1);
    push(n + 15, 3'b011, 0, 0, 0, 1);
    push(n + 16, 3'b111, 1, 0, 0, 1);
    while (sb.size() > 0) begin
      step();
      while (sb.size() > 0 && sb[0].e == ecnt) begin
        x = sb.pop_front();
        checks++;
        if ({rn0, rdy0, ack0} !== {x.rn, x.rdy, x.ack}) begin
          failures++;
          $display("FAIL warm_reset edge=%0d got rn=%b rdy=%b ack=%b exp rn=%b rdy=%b ack=%b",
                   ecnt, rn0, rdy0, ack0, x.rn, x.rdy, x.ack);
        end
        sw_rst_req = x.req; pll_lock = x.lock;
      end
    end
  endtask

  task automatic test_lock_loss();
    int l, r;
    l = ecnt + 2;
    r = l + 4;
    push(l - 1,  3'b111, 1, 0, 0, 0);  // lock low sampled at edge l
    push(l,      3'b111, 1, 0, 0, 0);
    push(l + 1,  3'b111, 1, 0, 0, 0);
    push(l + 2,  3'b000, 0, 0, 0, 0);
    push(r - 1,  3'b000, 0, 0, 0, 1);  // lock high again from edge r
    push(r + 10, 3'b000, 0, 0, 0, 1);
    push(r + 11, 3'b001, 0, 0, 0, 1);
    push(r + 15, 3'b011, 0, 0, 0, 1);
    push(r + 18, 3'b011, 0, 0, 0, 1);
    push(r + 19, 3'b111, 1, 0, 0, 1);
    while (sb.size() > 0) begin
      step();
      while (sb.size() > 0 && sb[0].e == ecnt) begin
        x = sb.pop_front();
        checks++;
        if ({rn0, rdy0, ack0} !== {x.rn, x.rdy, x.ack}) begin
          failures++;
          $display("FAIL lock_loss edge=%0d got rn=%b rdy=%b ack=%b exp rn=%b rdy=%b ack=%b",
                   ecnt, rn0, rdy0, ack0, x.rn, x.rdy, x.ack);
        end
        sw_rst_req = x.req; pll_lock = x.lock;
      end
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    release_rst();
    push(11, 3'b001, 0, 0, 0, 1); push(16, 3'b011, 0, 0, 0, 1);
    push(1000, 3'b000, 0, 0, 0, 1); // marker: sequence restarts before this edge
    void'(sb.pop_back());
    while (sb.size() > 0) begin
      step();
      while (sb.size() > 0 && sb[0].e == ecnt) begin
        x = sb.pop_front();
        checks++;
        if ({rn0, rdy0, ack0} !== {x.rn, x.rdy, x.ack}) begin
          failures++;
          $display("FAIL async_pre edge=%0d got rn=%b rdy=%b ack=%b exp rn=%b rdy=%b ack=%b",
                   ecnt, rn0, rdy0, ack0, x.rn, x.rdy, x.ack);
        end
      end
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({rn0, rdy0, ack0} !== 5'b0) begin
      failures++;
      $display("FAIL async_clear got rn=%b rdy=%b ack=%b exp all 0", rn0, rdy0, ack0);
    end
    step();
    release_rst();
    push(10, 3'b000, 0, 0, 0, 1); push(11, 3'b001, 0, 0, 0, 1);
    push(15, 3'b011, 0, 0, 0, 1); push(18, 3'b011, 0, 0, 0, 1);
    push(19, 3'b111, 1, 0, 0, 1);
    while (sb.size() > 0) begin
      step();
      while (sb.size() > 0 && sb[0].e == ecnt) begin
        x = sb.pop_front();
        checks++;
        if ({rn0, rdy0, ack0} !== {x.rn, x.rdy, x.ack}) begin
          failures++;
          $display("FAIL async_post edge=%0d got rn=%b rdy=%b ack=%b exp rn=%b rdy=%b ack=%b",
                   ecnt, rn0, rdy0, ack0, x.rn, x.rdy, x.ack);
        end
      end
    end
  endtask

  task automatic test_param_sweep();
    rst = 1'b1; pll_lock = 1'b1; sw_rst_req = 1'b0;
    release_rst();
    push(0, 3'b000, 0, 0, 0, 1);  push(10, 3'b000, 0, 0, 0, 1);
    push(11, 3'b001, 1, 0, 0, 1); push(13, 3'b001, 1, 0, 0, 1);
    while (sb.size() > 0) begin
      step();
      while (sb.size() > 0 && sb[0].e == ecnt) begin
        x = sb.pop_front();
        checks++;
        if ({rn1, rdy1, ack1} !== {x.rn[0], x.rdy, x.ack}) begin
          failures++;
          $display("FAIL param_sweep edge=%0d got rn=%b rdy=%b ack=%b exp rn=%b rdy=%b ack=%b",
                   ecnt, rn1, rdy1, ack1, x.rn[0], x.rdy, x.ack);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_late_lock();
    test_warm_reset();
    test_lock_loss();
    test_async_reset();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
